// File: rtl/cluster_rsp_demux_buf.sv
`default_nettype none
// ============================================================================
// Module      : cluster_rsp_demux_buf
// Description : Registered L2-response demultiplexer for one cluster. Each
//               beat is captured in a single input stage, then steered by the
//               SM-index field of its cluster source ID into that SM's private
//               show-ahead FIFO. A stalled SM only holds up the input stage
//               while its own beat waits; other SMs' queued beats keep flowing.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef NUM_SM_IN_CLUSTER
`define NUM_SM_IN_CLUSTER 2
`endif
`ifndef NUM_CLUSTER_DEPTH
`define NUM_CLUSTER_DEPTH 1
`endif
`ifndef D_SOURCE
`define D_SOURCE 4
`endif
`ifndef CLUSTER_SOURCE
`define CLUSTER_SOURCE 5
`endif
`ifndef ADDRESS_BITS
`define ADDRESS_BITS 32
`endif
`ifndef DATA_BITS
`define DATA_BITS 64
`endif

module cluster_rsp_demux_buf #(
    parameter int NUM_SM   = `NUM_SM_IN_CLUSTER,
    parameter int SM_IDX_W = `NUM_CLUSTER_DEPTH,
    parameter int D_SRC_W  = `D_SOURCE,
    parameter int CL_SRC_W = `CLUSTER_SOURCE,
    parameter int ADDR_W   = `ADDRESS_BITS,
    parameter int DATA_W   = `DATA_BITS,
    parameter int QDEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [2:0]                 in_opcode_i,
    input  logic [CL_SRC_W-1:0]        in_source_i,
    input  logic [ADDR_W-1:0]          in_address_i,
    input  logic [DATA_W-1:0]          in_data_i,
    output logic [NUM_SM-1:0]          out_valid_o,
    input  logic [NUM_SM-1:0]          out_ready_i,
    output logic [NUM_SM*3-1:0]        out_opcode_o,
    output logic [NUM_SM*D_SRC_W-1:0]  out_source_o,
    output logic [NUM_SM*ADDR_W-1:0]   out_address_o,
    output logic [NUM_SM*DATA_W-1:0]   out_data_o,
    output logic                       err_o
);

    localparam int          C_PTR_W  = $clog2(QDEPTH);
    localparam int          C_CNT_W  = C_PTR_W + 1;
    localparam int          C_PAY_W  = 3 + D_SRC_W + ADDR_W + DATA_W;
    localparam logic [31:0] C_NUM_SM = 32'(NUM_SM);

    // Input stage: the SM index is extracted at capture time so only the
    // per-SM part of the source ID travels with the payload.
    logic                   r_stg_valid;
    logic [SM_IDX_W-1:0]    r_stg_idx;
    logic [C_PAY_W-1:0]     r_stg_payload;

    logic [SM_IDX_W-1:0]    w_in_idx;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_tgt_full;
    logic                   w_drain;
    logic [NUM_SM-1:0]      w_full;
    logic [NUM_SM-1:0]      w_push;

    generate
        if (NUM_SM == 1) begin : g_idx_single
            assign w_in_idx = '0;
        end else begin : g_idx_multi
            assign w_in_idx = in_source_i[CL_SRC_W-1 -: SM_IDX_W];
        end
    endgenerate

    assign w_legal    = (32'(r_stg_idx) < C_NUM_SM);
    assign in_ready_o = !rst && (!r_stg_valid || w_drain);
    assign w_accept   = in_valid_i && in_ready_o;

    // Target-full lookup, drain decision and one-hot push to the target FIFO.
    always_comb begin
        w_tgt_full = 1'b0;
        w_push     = '0;
        for (int i = 0; i < NUM_SM; i++) begin
            if (32'(r_stg_idx) == 32'(i)) begin
                w_tgt_full = w_full[i];
            end
        end
        w_drain = r_stg_valid && (!w_legal || !w_tgt_full);
        for (int i = 0; i < NUM_SM; i++) begin
            w_push[i] = w_drain && w_legal && (32'(r_stg_idx) == 32'(i));
        end
    end

    // Stage occupancy: fill on accept, empty on drain without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_valid <= 1'b0;
        end else if (w_accept) begin
            r_stg_valid <= 1'b1;
        end else if (w_drain) begin
            r_stg_valid <= 1'b0;
        end
    end

    // Stage payload capture; contents are meaningless while the stage is empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_stg_idx     <= w_in_idx;
            r_stg_payload <= {in_opcode_i, in_source_i[D_SRC_W-1:0], in_address_i, in_data_i};
        end
    end

    // Sticky flag for beats discarded because their SM index has no port.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (w_drain && !w_legal) begin
            err_o <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SM; gi++) begin : g_sm
            logic [C_PAY_W-1:0] r_mem [QDEPTH];
            logic [C_PTR_W-1:0] r_wr_ptr;
            logic [C_PTR_W-1:0] r_rd_ptr;
            logic [C_CNT_W-1:0] r_cnt;
            logic               w_pop;

            // Full blocks the push even when a pop lands in the same cycle.
            assign w_full[gi] = (r_cnt == C_CNT_W'(QDEPTH));
            assign w_pop      = (r_cnt != '0) && out_ready_i[gi];

            // Pointer and occupancy bookkeeping; pointers wrap modulo QDEPTH.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    if (w_push[gi] && !w_pop) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (w_pop && !w_push[gi]) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end

            // Storage write; no reset needed since occupancy gates visibility.
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr] <= r_stg_payload;
                end
            end

            assign out_valid_o[gi] = (r_cnt != '0);
            assign {out_opcode_o[gi*3 +: 3],
                    out_source_o[gi*D_SRC_W +: D_SRC_W],
                    out_address_o[gi*ADDR_W +: ADDR_W],
                    out_data_o[gi*DATA_W +: DATA_W]} = r_mem[r_rd_ptr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cluster_rsp_demux_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_rsp_demux_buf
// Description : Directed, table-driven bench for cluster_rsp_demux_buf with a
//               two-SM instance (main traffic) and a three-SM instance with a
//               2-bit index field (illegal index handling).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_rsp_demux_buf;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Two-SM instance
    logic        a_vld;
    logic        a_in_ready;
    logic [2:0]  a_op;
    logic [4:0]  a_src;
    logic [7:0]  a_addr;
    logic [15:0] a_data;
    logic [1:0]  a_ov;
    logic [1:0]  a_rdy;
    logic [5:0]  a_oop;
    logic [7:0]  a_osrc;
    logic [15:0] a_oaddr;
    logic [31:0] a_odata;
    logic        a_err;

    // Three-SM instance
    logic        b_vld;
    logic        b_in_ready;
    logic [2:0]  b_op;
    logic [5:0]  b_src;
    logic [7:0]  b_addr;
    logic [15:0] b_data;
    logic [2:0]  b_ov;
    logic [2:0]  b_rdy;
    logic [8:0]  b_oop;
    logic [11:0] b_osrc;
    logic [23:0] b_oaddr;
    logic [47:0] b_odata;
    logic        b_err;

    cluster_rsp_demux_buf #(
        .NUM_SM(2), .SM_IDX_W(1), .D_SRC_W(4), .CL_SRC_W(5),
        .ADDR_W(8), .DATA_W(16), .QDEPTH(4)
    ) dut2 (
        .clk(clk), .rst(rst),
        .in_valid_i(a_vld), .in_ready_o(a_in_ready), .in_opcode_i(a_op),
        .in_source_i(a_src), .in_address_i(a_addr), .in_data_i(a_data),
        .out_valid_o(a_ov), .out_ready_i(a_rdy), .out_opcode_o(a_oop),
        .out_source_o(a_osrc), .out_address_o(a_oaddr), .out_data_o(a_odata),
        .err_o(a_err)
    );

    cluster_rsp_demux_buf #(
        .NUM_SM(3), .SM_IDX_W(2), .D_SRC_W(4), .CL_SRC_W(6),
        .ADDR_W(8), .DATA_W(16), .QDEPTH(4)
    ) dut3 (
        .clk(clk), .rst(rst),
        .in_valid_i(b_vld), .in_ready_o(b_in_ready), .in_opcode_i(b_op),
        .in_source_i(b_src), .in_address_i(b_addr), .in_data_i(b_data),
        .out_valid_o(b_ov), .out_ready_i(b_rdy), .out_opcode_o(b_oop),
        .out_source_o(b_osrc), .out_address_o(b_oaddr), .out_data_o(b_odata),
        .err_o(b_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    typedef struct packed {
        logic        vld;
        logic [4:0]  src;
        logic [15:0] data;
        logic [1:0]  rdy;
        logic        exp_ir;
        logic [1:0]  exp_ov;
        logic [3:0]  exp_src;
        logic [15:0] exp_data;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Compare the popped-beat log of one SM against base, base+1, ...
    task automatic chk_q(input string nm, input int sel, input logic [15:0] base, input int n);
        logic [15:0] got;
        int sz;
        sz = (sel == 0) ? q0.size() : q1.size();
        chk({nm, "_count"}, 64'(sz), 64'(n));
        for (int k = 0; k < n && k < sz; k++) begin
            got = (sel == 0) ? q0[k] : q1[k];
            chk($sformatf("%s_beat%0d", nm, k), 64'(got), 64'(base + 16'(k)));
        end
    endtask

    // Drive one beat on the two-SM instance and hold it until accepted.
    task automatic send_a(input logic [4:0] src, input logic [15:0] data);
        int w;
        step();
        a_vld  = 1'b1;
        a_src  = src;
        a_data = data;
        #1;
        w = 0;
        while (!a_in_ready && w < 50) begin
            step();
            #1;
            w++;
        end
        chk($sformatf("send_%0h_accepted", data), 64'(w < 50), 64'd1);
    endtask

    // Log every beat popped by the two-SM instance, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (a_ov[0] && a_rdy[0]) q0.push_back(a_odata[15:0]);
        if (a_ov[1] && a_rdy[1]) q1.push_back(a_odata[31:16]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          vld  src     data      rdy    ir    ov     src   data
        tbl[0]  = '{1'b1, 5'h00, 16'hA500, 2'b11, 1'b1, 2'b00, 4'h0, 16'h0000};
        tbl[1]  = '{1'b1, 5'h11, 16'hA501, 2'b11, 1'b1, 2'b00, 4'h0, 16'h0000};
        tbl[2]  = '{1'b1, 5'h02, 16'hA502, 2'b11, 1'b1, 2'b01, 4'h0, 16'hA500};
        tbl[3]  = '{1'b1, 5'h13, 16'hA503, 2'b11, 1'b1, 2'b10, 4'h1, 16'hA501};
        tbl[4]  = '{1'b1, 5'h04, 16'hA504, 2'b11, 1'b1, 2'b01, 4'h2, 16'hA502};
        tbl[5]  = '{1'b1, 5'h15, 16'hA505, 2'b11, 1'b1, 2'b10, 4'h3, 16'hA503};
        tbl[6]  = '{1'b1, 5'h06, 16'hA506, 2'b11, 1'b1, 2'b01, 4'h4, 16'hA504};
        tbl[7]  = '{1'b1, 5'h17, 16'hA507, 2'b11, 1'b1, 2'b10, 4'h5, 16'hA505};
        tbl[8]  = '{1'b0, 5'h00, 16'h0000, 2'b11, 1'b1, 2'b01, 4'h6, 16'hA506};
        tbl[9]  = '{1'b0, 5'h00, 16'h0000, 2'b11, 1'b1, 2'b10, 4'h7, 16'hA507};
        tbl[10] = '{1'b0, 5'h00, 16'h0000, 2'b11, 1'b1, 2'b00, 4'h0, 16'h0000};

        a_vld = 1'b0; a_op = 3'd0; a_src = '0; a_addr = '0; a_data = '0; a_rdy = 2'b11;
        b_vld = 1'b0; b_op = 3'd0; b_src = '0; b_addr = '0; b_data = '0; b_rdy = 3'b111;

        // Reset state
        repeat (2) step();
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd0);
        chk("rst_out_valid", 64'(a_ov), 64'd0);
        chk("rst_err", 64'(a_err), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);

        // Back-to-back alternating traffic
        for (int k = 0; k < 11; k++) begin
            step();
            a_vld  = tbl[k].vld;
            a_src  = tbl[k].src;
            a_data = tbl[k].data;
            a_rdy  = tbl[k].rdy;
            #1;
            chk($sformatf("tbl%0d_in_ready", k), 64'(a_in_ready), 64'(tbl[k].exp_ir));
            chk($sformatf("tbl%0d_out_valid", k), 64'(a_ov), 64'(tbl[k].exp_ov));
            for (int i = 0; i < 2; i++) begin
                if (tbl[k].exp_ov[i]) begin
                    chk($sformatf("tbl%0d_data%0d", k, i), 64'(a_odata[i*16 +: 16]), 64'(tbl[k].exp_data));
                    chk($sformatf("tbl%0d_src%0d", k, i), 64'(a_osrc[i*4 +: 4]), 64'(tbl[k].exp_src));
                end
            end
        end

        // Single beat to SM1: two-cycle latency, full payload
        step();
        a_vld = 1'b1; a_src = 5'h15; a_op = 3'd5; a_addr = 8'h3C; a_data = 16'hA5A5; a_rdy = 2'b11;
        #1;
        chk("sb_in_ready", 64'(a_in_ready), 64'd1);
        step();
        a_vld = 1'b0;
        #1;
        chk("sb_ov_cycle1", 64'(a_ov), 64'd0);
        step();
        #1;
        chk("sb_ov_cycle2", 64'(a_ov), 64'b10);
        chk("sb_src1", 64'(a_osrc[7:4]), 64'h5);
        chk("sb_data1", 64'(a_odata[31:16]), 64'hA5A5);
        chk("sb_op1", 64'(a_oop[5:3]), 64'd5);
        chk("sb_addr1", 64'(a_oaddr[15:8]), 64'h3C);
        step();
        #1;
        chk("sb_ov_after_pop", 64'(a_ov), 64'd0);

        // Head-of-line: SM0 stalled, stage blocks, one pop frees it
        step();
        q0 = {}; q1 = {};
        a_rdy = 2'b10; a_op = 3'd0; a_addr = 8'h00;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            a_vld = 1'b1; a_src = 5'(k); a_data = 16'hB000 + 16'(k);
            #1;
            chk($sformatf("hol_in_ready_%0d", k), 64'(a_in_ready), 64'd1);
        end
        step();
        a_src = 5'h05; a_data = 16'hB005;
        #1;
        chk("hol_stall", 64'(a_in_ready), 64'd0);
        chk("hol_ov", 64'(a_ov), 64'b01);
        chk("hol_head", 64'(a_odata[15:0]), 64'hB000);
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            chk($sformatf("hol_hold_%0d", k), 64'(a_in_ready), 64'd0);
        end
        step();
        a_rdy = 2'b11;
        #1;
        chk("hol_pop_cycle", 64'(a_in_ready), 64'd0);
        step();
        a_rdy = 2'b10;
        #1;
        chk("hol_resume", 64'(a_in_ready), 64'd1);
        step();
        a_vld = 1'b0; a_rdy = 2'b11;
        send_a(5'h10, 16'hC000);
        send_a(5'h11, 16'hC001);
        send_a(5'h12, 16'hC002);
        step();
        a_vld = 1'b0;
        repeat (12) step();
        chk_q("hol_sm0", 0, 16'hB000, 6);
        chk_q("hol_sm1", 1, 16'hC000, 3);

        // Full without bypass: 4 -> 3 -> 4
        step();
        q0 = {}; q1 = {};
        a_rdy = 2'b00;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            a_vld = 1'b1; a_src = 5'(k); a_data = 16'hD000 + 16'(k);
            #1;
            chk($sformatf("fnb_in_ready_%0d", k), 64'(a_in_ready), 64'd1);
        end
        step();
        a_src = 5'h05; a_data = 16'hD005; a_rdy = 2'b01;
        #1;
        chk("fnb_stall_with_pop", 64'(a_in_ready), 64'd0);
        step();
        a_rdy = 2'b00;
        #1;
        chk("fnb_after_pop", 64'(a_in_ready), 64'd1);
        chk("fnb_head", 64'(a_odata[15:0]), 64'hD001);
        step();
        a_vld = 1'b0;
        #1;
        chk("fnb_refull", 64'(a_in_ready), 64'd0);
        step();
        a_rdy = 2'b01;
        repeat (10) step();
        chk_q("fnb_sm0", 0, 16'hD000, 6);

        // Illegal index on the three-SM instance
        step();
        b_vld = 1'b1; b_src = 6'h37; b_data = 16'hEEEE;
        #1;
        chk("ill_in_ready", 64'(b_in_ready), 64'd1);
        step();
        b_vld = 1'b0;
        #1;
        chk("ill_err_stage", 64'(b_err), 64'd0);
        chk("ill_ov_stage", 64'(b_ov), 64'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            #1;
            chk($sformatf("ill_err_%0d", k), 64'(b_err), 64'd1);
            chk($sformatf("ill_ov_%0d", k), 64'(b_ov), 64'd0);
        end
        step();
        b_vld = 1'b1; b_src = 6'h29; b_data = 16'hE002;
        step();
        b_vld = 1'b0;
        step();
        #1;
        chk("sm2_ov", 64'(b_ov), 64'b100);
        chk("sm2_data", 64'(b_odata[47:32]), 64'hE002);
        chk("sm2_src", 64'(b_osrc[11:8]), 64'h9);
        chk("ill_err_sticky", 64'(b_err), 64'd1);

        // Reset mid-stream: FIFO1 holds 2 beats and the stage holds a third
        step();
        q0 = {}; q1 = {};
        a_rdy = 2'b00;
        a_vld = 1'b1; a_src = 5'h10; a_data = 16'hF000;
        step();
        a_src = 5'h11; a_data = 16'hF001;
        step();
        a_src = 5'h12; a_data = 16'hF002;
        step();
        a_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstm_ov_before", 64'(a_ov), 64'b10);
        chk("rstm_in_ready", 64'(a_in_ready), 64'd0);
        step();
        rst = 1'b0; a_rdy = 2'b11;
        #1;
        chk("rstm_ov", 64'(a_ov), 64'd0);
        chk("rstm_err3", 64'(b_err), 64'd0);
        chk("rstm_in_ready_after", 64'(a_in_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            #1;
            chk($sformatf("rstm_no_stale_%0d", k), 64'(a_ov), 64'd0);
        end
        chk("rstm_no_pops", 64'(q0.size() + q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
